// File: rtl/regfile_mp_pkg.sv
// rtl/regfile_mp_pkg.sv - shared types and constants for the multi-port register file
//
// Purpose: state encoding, read-source select encoding, default geometry and
// the default write-port bundle type.
// Ports: none (package).
package regfile_mp_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int DEPTH     = 2 ** RF_ADDR_W;

  typedef enum logic {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Where a registered read slot takes its data from.
  typedef enum logic [1:0] {
    RSEL_ZERO = 2'd0,
    RSEL_BYP  = 2'd1,
    RSEL_MEM  = 2'd2
  } rsel_e;

  // Write-port bundle at default geometry; the top declares an identically
  // shaped struct sized by its own parameters.
  typedef struct packed {
    logic [RF_ADDR_W-1:0] waddr;
    logic [RF_DATA_W-1:0] wdata;
    logic                 wren;
  } wr_port_t;

endpackage

// File: rtl/regfile_bank.sv
// rtl/regfile_bank.sv - one storage array with all write ports and one registered read port
//
// Purpose: storage replica serving a single read port. Write ports are applied
// in ascending index order, so on an address collision the highest index wins.
// Ports:
//   clock  in   rising-edge clock
//   wr     in   NUM_WR write-port bundles (waddr, wdata, wren)
//   raddr  in   read address
//   rdata  out  registered read data (stored value, no bypass)
module regfile_bank
  import regfile_mp_pkg::*;
#(
  parameter int  DATA_W = 32,
  parameter int  ADDR_W = 5,
  parameter int  NUM_WR = 2,
  parameter type wp_t   = wr_port_t
) (
  input  logic                 clock,
  input  wp_t   [NUM_WR-1:0]   wr,
  input  logic  [ADDR_W-1:0]   raddr,
  output logic  [DATA_W-1:0]   rdata
);

  localparam int NREGS = 2 ** ADDR_W;

  // Storage carries no reset; the top zeroes it with a sweep.
  logic [DATA_W-1:0] mem [NREGS];
  logic [DATA_W-1:0] rdata_d, rdata_q;

  always_comb begin
    rdata_d = mem[raddr];
  end

  always_ff @(posedge clock) begin
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr[j].wren) begin
        mem[wr[j].waddr] <= wr[j].wdata;
      end
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port register file with bypass, scoreboard and clear sweep
//
// Purpose: NUM_RD registered read ports (one storage bank each), NUM_WR write
// ports with same-cycle write-through bypass, a per-register pending bit and
// a zeroing sweep after reset or on clear_req.
// Ports:
//   clock, reset_n  clock and asynchronous active-low reset
//   raddr/rdata     read addresses and registered read data, packed per port
//   rbusy           registered pending bit of each read address
//   wren/waddr/wdata write ports, packed per port
//   sb_set/sb_addr  mark a register pending
//   clear_req       start a zeroing sweep
//   ready           high in RUN, low while sweeping
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic [NUM_RD-1:0]          rbusy,
  input  logic [NUM_WR-1:0]          wren,
  input  logic [NUM_WR*ADDR_W-1:0]   waddr,
  input  logic [NUM_WR*DATA_W-1:0]   wdata,
  input  logic                       sb_set,
  input  logic [ADDR_W-1:0]          sb_addr,
  input  logic                       clear_req,
  output logic                       ready
);

  localparam int NREGS = 2 ** ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              wren;
  } wp_t;

  state_e             state_q, state_d;
  // One extra bit: the sweep is done once the MSB sets, a cycle after the
  // last address has been written.
  logic [ADDR_W:0]    sweep_addr_q, sweep_addr_d;
  logic [NREGS-1:0]   pending_q, pending_d;
  rsel_e              rsel_q [NUM_RD];
  rsel_e              rsel_d [NUM_RD];
  logic [DATA_W-1:0]  rbyp_q [NUM_RD];
  logic [DATA_W-1:0]  rbyp_d [NUM_RD];
  logic [NUM_RD-1:0]  rbusy_q, rbusy_d;

  wp_t [NUM_WR-1:0]   user_wp, bank_wp;
  logic [ADDR_W-1:0]  rd_addr    [NUM_RD];
  logic [DATA_W-1:0]  bank_rdata [NUM_RD];

  // Incoming writes, with register 0 writes dropped when it is hard-wired.
  always_comb begin
    for (int j = 0; j < NUM_WR; j++) begin
      user_wp[j].waddr = waddr[j*ADDR_W +: ADDR_W];
      user_wp[j].wdata = wdata[j*DATA_W +: DATA_W];
      user_wp[j].wren  = wren[j] && !(ZERO_REG && (waddr[j*ADDR_W +: ADDR_W] == '0));
    end
  end

  // FSM, bank write ports and scoreboard update.
  always_comb begin
    state_d      = state_q;
    sweep_addr_d = sweep_addr_q;
    pending_d    = pending_q;
    bank_wp      = '0;
    case (state_q)
      SWEEP: begin
        if (sweep_addr_q[ADDR_W]) begin
          state_d = RUN;
        end else begin
          // Port 0 carries the zeroing write; the other ports stay idle.
          bank_wp[0].waddr = sweep_addr_q[ADDR_W-1:0];
          bank_wp[0].wren  = 1'b1;
          sweep_addr_d     = sweep_addr_q + 1'b1;
        end
      end
      RUN: begin
        if (clear_req) begin
          state_d      = SWEEP;
          sweep_addr_d = '0;
          pending_d    = '0;
        end else begin
          bank_wp = user_wp;
          for (int j = 0; j < NUM_WR; j++) begin
            if (user_wp[j].wren) pending_d[user_wp[j].waddr] = 1'b0;
          end
          // Applied after the clears so a same-cycle set wins.
          if (sb_set && !(ZERO_REG && (sb_addr == '0))) pending_d[sb_addr] = 1'b1;
        end
      end
      default: state_d = SWEEP;
    endcase
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    assign rd_addr[g] = raddr[g*ADDR_W +: ADDR_W];

    regfile_bank #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_WR (NUM_WR),
      .wp_t   (wp_t)
    ) u_bank (
      .clock (clock),
      .wr    (bank_wp),
      .raddr (rd_addr[g]),
      .rdata (bank_rdata[g])
    );
  end

  // Read source selection; ascending port scan lets the highest-index write win.
  always_comb begin
    rbusy_d = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rsel_d[i] = RSEL_ZERO;
      rbyp_d[i] = '0;
      if ((state_q == RUN) && !(ZERO_REG && (rd_addr[i] == '0))) begin
        rsel_d[i] = RSEL_MEM;
        for (int j = 0; j < NUM_WR; j++) begin
          if (bank_wp[j].wren && (bank_wp[j].waddr == rd_addr[i])) begin
            rsel_d[i] = RSEL_BYP;
            rbyp_d[i] = bank_wp[j].wdata;
          end
        end
        rbusy_d[i] = pending_d[rd_addr[i]];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= SWEEP;
      sweep_addr_q <= '0;
      pending_q    <= '0;
      rbusy_q      <= '0;
      for (int i = 0; i < NUM_RD; i++) begin
        rsel_q[i] <= RSEL_ZERO;
        rbyp_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      sweep_addr_q <= sweep_addr_d;
      pending_q    <= pending_d;
      rbusy_q      <= rbusy_d;
      for (int i = 0; i < NUM_RD; i++) begin
        rsel_q[i] <= rsel_d[i];
        rbyp_q[i] <= rbyp_d[i];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      case (rsel_q[i])
        RSEL_BYP: rdata[i*DATA_W +: DATA_W] = rbyp_q[i];
        RSEL_MEM: rdata[i*DATA_W +: DATA_W] = bank_rdata[i];
        default:  rdata[i*DATA_W +: DATA_W] = '0;
      endcase
    end
  end

  assign rbusy = rbusy_q;
  assign ready = (state_q == RUN);

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp
module tb_regfile_mp;

  logic        clock;
  logic        reset_n;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic [1:0]  wren;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic        clear_req;
  logic        ready;

  int checks = 0;
  int errors = 0;

  regfile_mp #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .NUM_RD   (2),
    .NUM_WR   (2),
    .ZERO_REG (1'b1)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .raddr     (raddr),
    .rdata     (rdata),
    .rbusy     (rbusy),
    .wren      (wren),
    .waddr     (waddr),
    .wdata     (wdata),
    .sb_set    (sb_set),
    .sb_addr   (sb_addr),
    .clear_req (clear_req),
    .ready     (ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wren      = 2'b00;
    waddr     = '0;
    wdata     = '0;
    sb_set    = 1'b0;
    sb_addr   = '0;
    clear_req = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    raddr = {a1, a0};
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    wren[p]         = 1'b1;
    waddr[p*5 +: 5] = a;
    wdata[p*32 +: 32] = d;
  endtask

  task automatic sweep_wait(input string tag);
    for (int k = 0; k < 32; k++) begin
      step();
      chk({tag, "_ready_low"}, {31'd0, ready}, 32'd0);
    end
    step();
    chk({tag, "_ready_high"}, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    rd(5'd0, 5'd0);
    step();
    step();
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_rdata0", rdata[31:0], 32'd0);
    chk("rst_rdata1", rdata[63:32], 32'd0);
    chk("rst_rbusy", {30'd0, rbusy}, 32'd0);

    reset_n = 1'b1;
    sweep_wait("init");

    for (int a = 1; a < 32; a++) begin
      rd(5'(a), 5'(32 - a));
      step();
      chk("init_rd0", rdata[31:0], 32'd0);
      chk("init_rd1", rdata[63:32], 32'd0);
      chk("init_busy", {30'd0, rbusy}, 32'd0);
    end

    // plain write then read on both ports
    rd(5'd0, 5'd0);
    wr(0, 5'd5, 32'hDEADBEEF);
    step();
    idle();
    rd(5'd5, 5'd5);
    step();
    chk("r5_rd0", rdata[31:0], 32'hDEADBEEF);
    chk("r5_rd1", rdata[63:32], 32'hDEADBEEF);

    // same-cycle bypass
    wr(0, 5'd7, 32'h12345678);
    rd(5'd7, 5'd5);
    step();
    idle();
    chk("byp_r7", rdata[31:0], 32'h12345678);
    chk("byp_r5", rdata[63:32], 32'hDEADBEEF);

    // collision: port 1 wins for storage and bypass
    wr(0, 5'd3, 32'h1);
    wr(1, 5'd3, 32'h2);
    rd(5'd3, 5'd3);
    step();
    idle();
    chk("coll_byp0", rdata[31:0], 32'h2);
    chk("coll_byp1", rdata[63:32], 32'h2);
    step();
    chk("coll_mem0", rdata[31:0], 32'h2);
    chk("coll_mem1", rdata[63:32], 32'h2);

    // different addresses commit together
    wr(0, 5'd10, 32'h0000_0010);
    wr(1, 5'd11, 32'h0000_0011);
    step();
    idle();
    rd(5'd10, 5'd11);
    step();
    chk("dual_r10", rdata[31:0], 32'h10);
    chk("dual_r11", rdata[63:32], 32'h11);

    // zero register
    wr(0, 5'd0, 32'hFFFFFFFF);
    sb_set  = 1'b1;
    sb_addr = 5'd0;
    rd(5'd0, 5'd0);
    step();
    idle();
    chk("r0_byp", rdata[31:0], 32'd0);
    chk("r0_byp_busy", {31'd0, rbusy[0]}, 32'd0);
    step();
    chk("r0_mem", rdata[31:0], 32'd0);
    chk("r0_mem_busy", {31'd0, rbusy[0]}, 32'd0);

    // scoreboard on r9
    sb_set  = 1'b1;
    sb_addr = 5'd9;
    rd(5'd9, 5'd9);
    step();
    idle();
    chk("sb_set_fwd", {30'd0, rbusy}, 32'd3);
    step();
    chk("sb_set_hold", {31'd0, rbusy[0]}, 32'd1);
    wr(0, 5'd9, 32'h0000_00AA);
    sb_set  = 1'b1;
    sb_addr = 5'd9;
    step();
    idle();
    chk("sb_setwins_busy", {31'd0, rbusy[0]}, 32'd1);
    chk("sb_setwins_data", rdata[31:0], 32'hAA);
    wr(1, 5'd9, 32'h0000_00BB);
    step();
    idle();
    chk("sb_clr_fwd", {31'd0, rbusy[0]}, 32'd0);
    step();
    chk("sb_clr_busy", {31'd0, rbusy[0]}, 32'd0);
    chk("sb_clr_data", rdata[31:0], 32'hBB);

    // clear sweep; writes and sets during it are ignored
    sb_set  = 1'b1;
    sb_addr = 5'd12;
    step();
    idle();
    rd(5'd5, 5'd12);
    step();
    chk("pre_clr_r5", rdata[31:0], 32'hDEADBEEF);
    chk("pre_clr_busy12", {31'd0, rbusy[1]}, 32'd1);
    clear_req = 1'b1;
    wr(0, 5'd5, 32'h0000_0055);
    step();
    idle();
    chk("clr_edge_ready", {31'd0, ready}, 32'd0);
    for (int k = 0; k < 32; k++) begin
      wr(0, 5'd5, 32'h77);
      wr(1, 5'd6, 32'h66);
      sb_set  = 1'b1;
      sb_addr = 5'd13;
      step();
      chk("clr_ready_low", {31'd0, ready}, 32'd0);
      chk("clr_rdata_zero", rdata[31:0], 32'd0);
    end
    idle();
    step();
    chk("clr_ready_high", {31'd0, ready}, 32'd1);
    rd(5'd5, 5'd12);
    step();
    chk("clr_r5", rdata[31:0], 32'd0);
    chk("clr_busy12", {31'd0, rbusy[1]}, 32'd0);
    rd(5'd6, 5'd13);
    step();
    chk("clr_r6", rdata[31:0], 32'd0);
    chk("clr_busy13", {31'd0, rbusy[1]}, 32'd0);

    // reset in the middle of a sweep restarts it
    wr(0, 5'd20, 32'hCAFE_F00D);
    step();
    idle();
    clear_req = 1'b1;
    step();
    idle();
    for (int k = 0; k < 10; k++) step();
    reset_n = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, ready}, 32'd0);
    step();
    step();
    reset_n = 1'b1;
    sweep_wait("midrst");
    rd(5'd20, 5'd11);
    step();
    chk("midrst_r20", rdata[31:0], 32'd0);
    chk("midrst_r11", rdata[63:32], 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
